// File: rtl/oled_window_sched.sv
// ============================================================================
// Module : oled_window_sched
// Brief  : Paints one ST7735 window as CASET/RASET/RAMWR followed by RGB565 pixel bytes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module oled_window_sched #(
    parameter int C_x_bits   = 7,
    parameter int C_y_bits   = 8,
    parameter int C_x_max    = 127,
    parameter int C_y_max    = 159,
    parameter int C_x_offset = 0,
    parameter int C_y_offset = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_done,
    input  logic                start,
    input  logic [C_x_bits-1:0] win_x0,
    input  logic [C_x_bits-1:0] win_x1,
    input  logic [C_y_bits-1:0] win_y0,
    input  logic [C_y_bits-1:0] win_y1,
    output logic [C_x_bits-1:0] x,
    output logic [C_y_bits-1:0] y,
    input  logic [15:0]         color,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    output logic                byte_dc,
    input  logic                byte_ready,
    output logic                busy,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_HI    = 3'd3,
        S_LO    = 3'd4,
        S_ADV   = 3'd5
    } state_t;

    localparam logic [C_x_bits-1:0] c_x_max = C_x_bits'(C_x_max);
    localparam logic [C_y_bits-1:0] c_y_max = C_y_bits'(C_y_max);
    localparam logic [3:0]          c_hdr_last = 4'd10;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [C_x_bits-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
    logic [C_y_bits-1:0] y_q, y_d, y0_q, y0_d, y1_q, y1_d;
    logic [7:0]          color_lo_q, color_lo_d;
    logic                valid_q, valid_d;
    logic [7:0]          data_q, data_d;
    logic                dc_q, dc_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                hs;
    logic                win_bad;
    logic [8:0]          hdr_next;

    assign hs      = valid_q & byte_ready;
    assign win_bad = (win_x0 > win_x1) || (win_y0 > win_y1) ||
                     (win_x1 > c_x_max) || (win_y1 > c_y_max);

    // {dc, byte} of header entry i; coordinates come from the latched window
    function automatic logic [8:0] hdr_byte(input logic [3:0] i);
        logic [8:0] r;
        case (i)
            4'd0:    r = {1'b0, 8'h2A};
            4'd2:    r = {1'b1, 8'(x0_q) + 8'(C_x_offset)};
            4'd4:    r = {1'b1, 8'(x1_q) + 8'(C_x_offset)};
            4'd5:    r = {1'b0, 8'h2B};
            4'd7:    r = {1'b1, 8'(y0_q) + 8'(C_y_offset)};
            4'd9:    r = {1'b1, 8'(y1_q) + 8'(C_y_offset)};
            4'd10:   r = {1'b0, 8'h2C};
            default: r = {1'b1, 8'h00};
        endcase
        return r;
    endfunction

    assign hdr_next = hdr_byte(idx_q + 4'd1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        x_d        = x_q;
        y_d        = y_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        color_lo_d = color_lo_q;
        valid_d    = valid_q;
        data_d     = data_q;
        dc_d       = dc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && init_done) begin
                    if (win_bad) begin
                        error_d = 1'b1;
                    end else begin
                        x0_d    = win_x0;
                        x1_d    = win_x1;
                        y0_d    = win_y0;
                        y1_d    = win_y1;
                        x_d     = win_x0;
                        y_d     = win_y0;
                        busy_d  = 1'b1;
                        idx_d   = 4'd0;
                        valid_d = 1'b1;
                        data_d  = 8'h2A;
                        dc_d    = 1'b0;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (hs) begin
                    if (idx_q == c_hdr_last) begin
                        idx_d   = 4'd0;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        idx_d          = idx_q + 4'd1;
                        {dc_d, data_d} = hdr_next;
                    end
                end
            end
            S_FETCH: begin
                // High byte goes straight out; only the low byte needs holding
                color_lo_d = color[7:0];
                valid_d    = 1'b1;
                data_d     = color[15:8];
                dc_d       = 1'b1;
                state_d    = S_HI;
            end
            S_HI: begin
                if (hs) begin
                    data_d  = color_lo_q;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (hs) begin
                    valid_d = 1'b0;
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (x_q < x1_q) begin
                    x_d     = x_q + C_x_bits'(1);
                    state_d = S_FETCH;
                end else if (y_q < y1_q) begin
                    x_d     = x0_q;
                    y_d     = y_q + C_y_bits'(1);
                    state_d = S_FETCH;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            x_q        <= '0;
            y_q        <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            color_lo_q <= 8'h00;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            dc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            color_lo_q <= color_lo_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            dc_q       <= dc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign byte_dc    = dc_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_window_sched.sv
// ============================================================================
// Module : tb_oled_window_sched
// Brief  : Directed self-checking bench for oled_window_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_oled_window_sched;

    logic        clk = 1'b0;
    logic        reset, init_done, start, start2;
    logic [6:0]  win_x0, win_x1, x, x2;
    logic [7:0]  win_y0, win_y1, y, y2;
    logic [15:0] color;
    logic        byte_valid, byte_dc, byte_ready, busy, done, error;
    logic [7:0]  byte_data;
    logic        bv2, bdc2, busy2, done2, err2;
    logic [7:0]  bd2;
    logic        col_mode, toggle;
    int          tick = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    assign color      = col_mode ? {1'b0, x, y} : 16'hF800;
    assign byte_ready = !toggle || (tick % 3 == 0);

    oled_window_sched dut (
        .clk(clk), .reset(reset), .init_done(init_done), .start(start),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .x(x), .y(y), .color(color),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
        .byte_ready(byte_ready), .busy(busy), .done(done), .error(error)
    );

    oled_window_sched #(.C_x_offset(2), .C_y_offset(1)) dut_off (
        .clk(clk), .reset(reset), .init_done(init_done), .start(start2),
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
        .x(x2), .y(y2), .color(16'h1234),
        .byte_valid(bv2), .byte_data(bd2), .byte_dc(bdc2),
        .byte_ready(1'b1), .busy(busy2), .done(done2), .error(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte and coordinate collector for the main instance
    logic [7:0] qd[$];
    logic       qdc[$];
    int         qx[$], qy[$];
    logic       stall_p = 1'b0, pdc = 1'b0, busy_p = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [6:0] x_p = 7'd0;
    logic [7:0] y_p = 8'd0;

    always @(negedge clk) begin
        if (!reset) begin
            if (stall_p)
                check("stall_hold", {byte_valid, byte_dc, byte_data}, {1'b1, pdc, pd});
            if (byte_valid && byte_ready) begin
                qd.push_back(byte_data);
                qdc.push_back(byte_dc);
            end
            if (busy && (!busy_p || x != x_p || y != y_p)) begin
                qx.push_back(int'(x));
                qy.push_back(int'(y));
            end
        end
        stall_p = byte_valid && !byte_ready && !reset;
        pd      = byte_data;
        pdc     = byte_dc;
        busy_p  = busy;
        x_p     = x;
        y_p     = y;
    end

    // Called #1 after a rising edge; returns #1 after a rising edge
    task automatic run_window(input int x0, input int x1, input int y0, input int y1,
                              output int cyc);
        logic seen;
        win_x0 = 7'(x0); win_x1 = 7'(x1);
        win_y0 = 8'(y0); win_y1 = 8'(y1);
        qd.delete(); qdc.delete(); qx.delete(); qy.delete();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("first_busy", busy, 1);
                check("first_byte", {byte_valid, byte_dc, byte_data}, {1'b1, 1'b0, 8'h2A});
            end
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("busy_at_done", busy, 0);
        @(posedge clk); #1;
    endtask

    logic [7:0] e2_d  [15];
    logic       e2_dc [15];
    logic [7:0] e4_d  [13];
    logic [7:0] r2d[$];
    logic       r2dc[$];

    initial begin
        int   cyc;
        int   k;
        logic flag;
        logic [15:0] c;

        e2_d  = '{8'h2A, 8'h00, 8'h02, 8'h00, 8'h03, 8'h2B, 8'h00, 8'h05,
                  8'h00, 8'h05, 8'h2C, 8'hF8, 8'h00, 8'hF8, 8'h00};
        e2_dc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        e4_d  = '{8'h2A, 8'h00, 8'h02, 8'h00, 8'h02, 8'h2B, 8'h00, 8'h01,
                  8'h00, 8'h01, 8'h2C, 8'h12, 8'h34};

        reset = 1'b1; init_done = 1'b0; start = 1'b0; start2 = 1'b0;
        col_mode = 1'b0; toggle = 1'b0;
        win_x0 = 7'd0; win_x1 = 7'd0; win_y0 = 8'd0; win_y1 = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", byte_valid, 0);
        check("rst_data", byte_data, 8'h00);
        check("rst_dc", byte_dc, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        // start ignored while init not done
        @(posedge clk); #1;
        win_x0 = 7'd0; win_x1 = 7'd127; win_y0 = 8'd0; win_y1 = 8'd159;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (byte_valid || busy || error) flag = 1'b1;
        end
        check("no_init_quiet", flag, 0);

        // two-pixel window, ready constantly high
        @(posedge clk); #1 init_done = 1'b1;
        run_window(2, 3, 5, 5, cyc);
        check("latency_2px", cyc, 20);
        check("bytes_2px", qd.size(), 15);
        for (int i = 0; i < 15 && i < qd.size(); i++) begin
            check("byte_2px", {qdc[i], qd[i]}, {e2_dc[i], e2_d[i]});
        end
        check("xy_count", qx.size(), 2);
        if (qx.size() == 2) begin
            check("xy0", {qx[0], qy[0]}, {32'd2, 32'd5});
            check("xy1", {qx[1], qy[1]}, {32'd3, 32'd5});
        end

        // same window with back-pressure
        toggle = 1'b1;
        run_window(2, 3, 5, 5, cyc);
        toggle = 1'b0;
        check("bytes_stall", qd.size(), 15);
        for (int i = 0; i < 15 && i < qd.size(); i++) begin
            check("byte_stall", {qdc[i], qd[i]}, {e2_dc[i], e2_d[i]});
        end

        // panel offsets on the second instance
        win_x0 = 7'd0; win_x1 = 7'd0; win_y0 = 8'd0; win_y1 = 8'd0;
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        flag = 1'b0;
        k = 0;
        while (!flag && k < 200) begin
            @(negedge clk);
            k++;
            if (bv2) begin
                r2d.push_back(bd2);
                r2dc.push_back(bdc2);
            end
            if (done2) flag = 1'b1;
        end
        check("off_done", flag, 1);
        check("off_bytes", r2d.size(), 13);
        for (int i = 0; i < 13 && i < r2d.size(); i++) begin
            check("off_byte", r2d[i], e4_d[i]);
        end
        @(posedge clk); #1;

        // rejected windows
        win_x0 = 7'd10; win_x1 = 7'd5; win_y0 = 8'd0; win_y1 = 8'd0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("err_x_pulse", {error, busy, byte_valid}, 3'b100);
        @(negedge clk);
        check("err_x_clear", {error, busy, byte_valid}, 3'b000);
        @(posedge clk); #1;
        win_x0 = 7'd0; win_x1 = 7'd5; win_y0 = 8'd0; win_y1 = 8'd160;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("err_y_pulse", {error, busy, byte_valid}, 3'b100);
        @(negedge clk);
        check("err_y_clear", {error, busy, byte_valid}, 3'b000);

        // reset mid-transfer, then repaint
        @(posedge clk); #1;
        col_mode = 1'b1;
        win_x0 = 7'd0; win_x1 = 7'd15; win_y0 = 8'd0; win_y1 = 8'd9;
        qd.delete(); qdc.delete();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (qd.size() < 111 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached", qd.size() >= 111, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_outs", {byte_valid, byte_dc, byte_data, busy, done, error}, 13'd0);
        check("mid_rst_xy", {x, y}, 15'd0);
        @(posedge clk); #1 reset = 1'b0;
        qd.delete(); qdc.delete();
        repeat (20) @(negedge clk);
        check("post_rst_silent", qd.size(), 0);
        @(posedge clk); #1;
        run_window(0, 15, 0, 9, cyc);
        check("latency_160px", cyc, 652);
        check("bytes_160px", qd.size(), 331);
        if (qd.size() == 331) begin
            check("rp_caset_x1", qd[4], 8'h0F);
            check("rp_raset_y1", qd[9], 8'h09);
            check("rp_ramwr", {qdc[10], qd[10]}, {1'b0, 8'h2C});
            k = 11;
            for (int yy = 0; yy <= 9; yy++) begin
                for (int xx = 0; xx <= 15; xx++) begin
                    c = {1'b0, 7'(xx), 8'(yy)};
                    check("rp_hi", {qdc[k], qd[k]}, {1'b1, c[15:8]});
                    check("rp_lo", {qdc[k+1], qd[k+1]}, {1'b1, c[7:0]});
                    k += 2;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/oled_window_sched.md
# oled_window_sched

Sequencer that paints a rectangular window of the ST7735 panel from a per-pixel colour source. On a start request it emits the column/row address-set commands and RAMWR as a command/data byte stream, then scans x/y over the window, fetching one RGB565 colour per pixel and emitting it as two data bytes. It sits between the pixel-colour logic (same combinational x/y→colour style as the checkered pattern) and the SPI byte serializer of the OLED driver.

## Interface
- C_x_bits, 7, width of x coordinate
- C_y_bits, 8, width of y coordinate
- C_x_max, 127, largest legal column
- C_y_max, 159, largest legal row
- C_x_offset, 0, panel column offset added to x0/x1 in CASET (8-bit, mod 256)
- C_y_offset, 0, panel row offset added to y0/y1 in RASET (8-bit, mod 256)

- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- init_done  in  1  panel init sequence complete; start ignored while low
- start  in  1  one-cycle window request
- win_x0, win_x1  in  C_x_bits  inclusive column bounds
- win_y0, win_y1  in  C_y_bits  inclusive row bounds
- x  out  C_x_bits  current pixel column
- y  out  C_y_bits  current pixel row
- color  in  16  RGB565 for (x,y); must be valid 1 cycle after x/y change
- byte_valid  out  1  byte offered to serializer
- byte_data  out  8  byte value
- byte_dc  out  1  0 = command, 1 = data
- byte_ready  in  1  serializer accepts byte when byte_valid & byte_ready
- busy  out  1  window transfer in progress
- done  out  1  one-cycle pulse, window finished
- error  out  1  one-cycle pulse, start rejected (bad window)

## Operation
- States: IDLE, HDR, FETCH, HI, LO, ADV.
- IDLE: on start & init_done, latch window. If win_x0>win_x1, win_y0>win_y1, win_x1>C_x_max or win_y1>C_y_max: pulse error next cycle, stay IDLE. Else x←win_x0, y←win_y0, busy←1, enter HDR at index 0.
- HDR: 11 bytes in order, index 0..10: 0x2A(dc0), 0x00, x0+C_x_offset, 0x00, x1+C_x_offset (dc1), 0x2B(dc0), 0x00, y0+C_y_offset, 0x00, y1+C_y_offset (dc1), 0x2C(dc0). Index advances on handshake; after index 10 → FETCH.
- FETCH: one cycle, color_q←color; byte_valid low. → HI.
- HI: offer color_q[15:8], dc1; on handshake → LO.
- LO: offer color_q[7:0], dc1; on handshake → ADV.
- ADV: one cycle. If x<x1: x←x+1 → FETCH. Else if y<y1: x←x0, y←y+1 → FETCH. Else → IDLE, busy←0, done←1 for one cycle.
- start while busy, or while init_done low: ignored, no error.
- Single-pixel window (x0=x1, y0=y1) legal: header + 2 bytes.

## Timing
- Reset values: byte_valid 0, byte_data 0x00, byte_dc 0, x 0, y 0, busy 0, done 0, error 0; state IDLE, HDR index 0.
- All outputs registered. byte_valid, byte_data, byte_dc held stable until handshake; byte_valid never drops without a handshake except by reset.
- start in cycle N (valid window): busy=1 and first byte (0x2A) offered in N+1.
- Per pixel with byte_ready constantly 1: 4 cycles (FETCH, HI, LO, ADV); header 11 cycles. Full 128×160 window: 1+11+4·20480 cycles start→done.
- done and busy=0 assert in the same cycle, the cycle after ADV of the last pixel.
- Reset mid-transfer: next cycle all outputs at reset values; no further bytes; panel left mid-RAMWR (next window's CASET recovers).
- Invalid start at cycle N: error=1 in N+1 only; busy stays 0; no bytes.

## Test plan
- Reset, init_done=0, start with window 0..127×0..159 → no byte_valid, busy 0, error 0 for 50 cycles.
- init_done=1, window x 2..3, y 5..5, color=16'hF800, ready=1 → bytes 2A,00,02,00,03,2B,00,05,00,05,2C (dc 0,1,1,1,1,0,1,1,1,1,0), then F8,00,F8,00 dc1; done 11+8+1 cycles after start; x/y sequence (2,5),(3,5).
- Same window, byte_ready toggling 1-in-3 → identical byte sequence, data stable while valid&!ready.
- C_x_offset=2, C_y_offset=1, window x 0..0, y 0..0 → CASET data 00,02,00,02; RASET 00,01,00,01; 2 pixel bytes.
- start with win_x0=10, win_x1=5 → error pulse 1 cycle, no bytes; then win_y1=160 → error pulse.
- Full-screen checkered source, reset asserted at pixel 1000 → byte_valid 0 next cycle, outputs at reset values; new start repaints correctly with 40960 pixel bytes.
